divider_arbiter: RTL and testbench

Round-robin controller that shares one fixed-point `divider` instance between `NUM_REQ` requesters. It accepts one request at a time and screens out divide-by-zero, which would otherwise hang the divider's normalisation loop. It then sequences the divider handshake, bounds each job with a timeout, and returns the quotient on a per-requester response channel. Because `divider` never leaves DONE on its own, this block re-arms it with a reset pulse after every job.

---
 rtl/divider_arbiter.sv | 153 +++++++++++++++
 tb/tb_divider_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin front end that shares one fixed-point divider
// between NUM_REQ requesters. It filters divide-by-zero, bounds each job with
// a timeout, and re-arms the divider with a reset pulse after every job.
module divider_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_n,
  input  logic [NUM_REQ*WIDTH-1:0] req_d,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     div_rst,
  output logic                     div_in_valid,
  output logic [WIDTH-1:0]         div_n,
  output logic [WIDTH-1:0]         div_d,
  input  logic                     div_ready,
  input  logic                     div_out_valid,
  input  logic [WIDTH-1:0]         div_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_RECOVER
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [PTR_W-1:0]         ptr;
  logic [PTR_W-1:0]         grant;
  logic [PTR_W-1:0]         hit_idx;
  logic [PTR_W-1:0]         resp_sel;
  logic                     hit;
  logic [CNT_W-1:0]         to_cnt;
  logic                     to_hit;
  logic signed [WIDTH-1:0]  n_sel;
  logic signed [WIDTH-1:0]  d_sel;
  logic signed [WIDTH-1:0]  n_q;
  logic signed [WIDTH-1:0]  d_q;

  // Saturated quotient for a zero divisor: largest magnitude with the dividend's sign.
  function automatic logic signed [WIDTH-1:0] sat_div0(input logic signed [WIDTH-1:0] n);
    sat_div0 = n[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    hit     = 1'b0;
    hit_idx = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      int               idx;
      logic [PTR_W-1:0] idx_w;
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PTR_W'(idx);
      if (!hit && req_valid[idx_w]) begin
        hit     = 1'b1;
        hit_idx = idx_w;
      end
    end
  end

  assign n_sel    = req_n[hit_idx*WIDTH +: WIDTH];
  assign d_sel    = req_d[hit_idx*WIDTH +: WIDTH];
  assign to_hit   = (to_cnt == CNT_W'(TIMEOUT - 1));
  assign resp_sel = (state == S_IDLE) ? hit_idx : grant;

  assign div_n        = n_q;
  assign div_d        = d_q;
  assign div_in_valid = (state == S_ISSUE) && div_ready;
  // Divider is held in reset whenever this block is, so a dropped job cannot linger.
  assign div_rst      = !rst || (state == S_RECOVER);

  // Accept strobe: only in IDLE, only for the arbitration winner.
  always_comb begin
    req_ready = '0;
    if (rst && state == S_IDLE && hit) req_ready[hit_idx] = 1'b1;
  end

  // Next-state decode for the job sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (hit) state_nxt = (d_sel == '0) ? S_RESP : S_ISSUE;
      S_ISSUE:   if (div_ready) state_nxt = S_WAIT;
      S_WAIT:    if (div_out_valid || to_hit) state_nxt = S_RESP;
      S_RESP:    if (resp_ready[grant]) state_nxt = S_RECOVER;
      S_RECOVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State, arbitration pointer, operand latch, timeout counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      grant      <= '0;
      to_cnt     <= '0;
      n_q        <= '0;
      d_q        <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      resp_valid <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (hit) begin
            grant <= hit_idx;
            ptr   <= (hit_idx == PTR_W'(NUM_REQ - 1)) ? '0 : hit_idx + 1'b1;
            n_q   <= n_sel;
            d_q   <= d_sel;
            if (d_sel == '0) begin
              resp_data <= sat_div0(n_sel);
              resp_err  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (div_ready) to_cnt <= '0;
        end
        S_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          // A result on the last WAIT cycle beats the timeout.
          if (div_out_valid) begin
            resp_data <= div_out;
            resp_err  <= 1'b0;
          end else if (to_hit) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
      resp_valid <= '0;
      if (state_nxt == S_RESP) resp_valid[resp_sel] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed and randomized checks of divider_arbiter
// against a behavioural divider and a round-robin/latency reference model.
module tb_divider_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_valid = 4'b0;
  logic [3:0]   req_ready;
  logic [127:0] req_n = '0;
  logic [127:0] req_d = '0;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready = 4'b0;
  logic [31:0]  resp_data;
  logic         resp_err;
  logic         div_rst;
  logic         div_in_valid;
  logic [31:0]  div_n;
  logic [31:0]  div_d;
  logic         div_ready = 1'b0;
  logic         div_out_valid = 1'b0;
  logic [31:0]  div_out = 32'b0;

  int compared   = 0;
  int mismatched = 0;
  int model_ptr  = 0;

  always #5 clk = ~clk;

  divider_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_d(req_d),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .div_rst(div_rst), .div_in_valid(div_in_valid),
    .div_n(div_n), .div_d(div_d),
    .div_ready(div_ready), .div_out_valid(div_out_valid), .div_out(div_out)
  );

  // Q16.16 signed quotient, truncated toward zero.
  function automatic logic [31:0] q_model(input logic [31:0] n, input logic [31:0] d);
    longint nn, dd, q;
    nn = longint'(signed'(n));
    dd = longint'(signed'(d));
    q  = (nn * 64'sd65536) / dd;
    return q[31:0];
  endfunction

  // Round-robin reference: first set bit of mask at or after p, wrapping.
  function automatic int rr_pick(input int p, input logic [3:0] mask);
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (p + i) % NUM_REQ;
      if (mask[k[1:0]]) return k;
    end
    return -1;
  endfunction

  // Behavioural divider: result div_lat cycles after start, held until div_rst.
  int          div_lat  = 3;
  bit          div_hang = 1'b0;
  bit          div_busy = 1'b0;
  int          div_cnt  = 0;
  logic [31:0] div_res  = 32'b0;
  int          cyc      = 0;
  int          in_cnt   = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_in_valid) in_cnt <= in_cnt + 1;
    if (div_rst) begin
      div_busy      <= 1'b0;
      div_out_valid <= 1'b0;
      div_ready     <= 1'b1;
    end else if (div_in_valid && div_ready) begin
      div_ready <= 1'b0;
      div_busy  <= 1'b1;
      div_cnt   <= div_lat;
      div_res   <= q_model(div_n, div_d);
    end else if (div_busy && !div_out_valid && !div_hang) begin
      if (div_cnt <= 1) begin
        div_out_valid <= 1'b1;
        div_out       <= div_res;
      end else begin
        div_cnt <= div_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int g, input logic [31:0] n, input logic [31:0] d);
    req_n[g*32 +: 32] = n;
    req_d[g*32 +: 32] = d;
  endtask

  // One complete job: grant, response, optional backpressure, recovery pulse.
  task automatic serve(input bit keep, input int hold, input logic [3:0] extra, input string tag);
    int          g, c, r, in0, lat;
    bit          got;
    logic [31:0] en, ed, exp_data;
    logic        exp_err;
    logic [3:0]  oh;
    g = rr_pick(model_ptr, req_valid);
    if (g < 0) g = 0;
    oh  = 4'b0001 << g;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (req_ready != 4'b0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, " grant_seen"}, 64'(got), 64'd1);
    if (!got) return;
    check({tag, " req_ready"}, 64'(req_ready), 64'(oh));
    en        = req_n[g*32 +: 32];
    ed        = req_d[g*32 +: 32];
    model_ptr = (g + 1) % NUM_REQ;
    in0       = in_cnt;
    c         = cyc;
    if (ed == 32'b0) begin
      exp_data = en[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      exp_err  = 1'b1;
      lat      = 1;
    end else if (!div_hang && div_lat <= TIMEOUT - 1) begin
      exp_data = q_model(en, ed);
      exp_err  = 1'b0;
      lat      = div_lat + 3;
    end else begin
      exp_data = 32'b0;
      exp_err  = 1'b1;
      lat      = TIMEOUT + 2;
    end
    got = 1'b0;
    for (int k = 0; k < TIMEOUT + 20; k++) begin
      @(negedge clk); #1;
      if (k == 0) begin
        if (!keep) req_valid = req_valid & ~oh;
        req_valid = req_valid | extra;
      end
      if (resp_valid != 4'b0) begin got = 1'b1; break; end
    end
    r = cyc;
    check({tag, " resp_seen"}, 64'(got), 64'd1);
    if (!got) return;
    check({tag, " resp_valid"}, 64'(resp_valid), 64'(oh));
    check({tag, " resp_data"}, 64'(resp_data), 64'(exp_data));
    check({tag, " resp_err"}, 64'(resp_err), 64'(exp_err));
    check({tag, " latency"}, 64'(r - c), 64'(lat));
    check({tag, " start_pulses"}, 64'(in_cnt - in0), (ed == 32'b0) ? 64'd0 : 64'd1);
    resp_ready = ~oh;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk); #1;
      check({tag, " hold resp_valid"}, 64'(resp_valid), 64'(oh));
      check({tag, " hold resp_data"}, 64'(resp_data), 64'(exp_data));
      check({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = oh;
    @(negedge clk); #1;
    resp_ready = 4'b0;
    check({tag, " recover div_rst"}, 64'(div_rst), 64'd1);
    check({tag, " recover resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, " recover req_ready"}, 64'(req_ready), 64'd0);
    @(negedge clk); #1;
    check({tag, " idle div_rst"}, 64'(div_rst), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all requesters asking: nothing may be accepted.
    rst       = 1'b0;
    req_valid = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_data", 64'(resp_data), 64'd0);
    check("rst resp_err", 64'(resp_err), 64'd0);
    check("rst div_in_valid", 64'(div_in_valid), 64'd0);
    check("rst div_n", 64'(div_n), 64'd0);
    check("rst div_d", 64'(div_d), 64'd0);
    check("rst div_rst", 64'(div_rst), 64'd1);
    req_valid = 4'b0;
    rst       = 1'b1;
    @(negedge clk);

    // Single job: 6.0 / 2.0.
    set_ops(0, 32'h0006_0000, 32'h0002_0000);
    req_valid = 4'b0001;
    div_lat   = 3;
    serve(1'b0, 1, 4'b0, "single");

    // Divide-by-zero with both dividend signs.
    set_ops(1, 32'h0001_0000, 32'h0);
    req_valid = 4'b0010;
    serve(1'b0, 1, 4'b0, "div0_pos");
    set_ops(2, 32'hFFFF_0000, 32'h0);
    req_valid = 4'b0100;
    serve(1'b0, 1, 4'b0, "div0_neg");

    // All requesters held valid: grants must rotate.
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, $urandom, $urandom_range(1, 32'h7FFF_FFFF));
    req_valid = 4'hF;
    for (int j = 0; j < 5; j++) begin
      div_lat = $urandom_range(1, 6);
      serve(1'b1, 1, 4'b0, "rr");
    end
    req_valid = 4'b0;

    // Random arrivals, operands and divider latencies.
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i[1:0]] && $urandom_range(0, 1) == 1) begin
          req_valid[i[1:0]] = 1'b1;
          set_ops(i, $urandom, ($urandom_range(0, 4) == 0) ? 32'b0 : $urandom);
        end
      end
      if (req_valid == 4'b0) begin
        req_valid[0] = 1'b1;
        set_ops(0, $urandom, $urandom);
      end
      div_lat = $urandom_range(1, 10);
      serve(1'b0, 1, 4'b0, "rand");
    end
    req_valid = 4'b0;

    // Divider never answers; then answers on the last WAIT cycle; then one cycle too late.
    set_ops(0, 32'h0005_0000, 32'h0001_0000);
    req_valid = 4'b0001;
    div_hang  = 1'b1;
    serve(1'b0, 1, 4'b0, "timeout");
    div_hang  = 1'b0;
    req_valid = 4'b0001;
    div_lat   = TIMEOUT - 1;
    serve(1'b0, 1, 4'b0, "last_wait");
    req_valid = 4'b0001;
    div_lat   = TIMEOUT;
    serve(1'b0, 1, 4'b0, "late_result");

    // Backpressure on requester 1 while others queue up.
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, $urandom, $urandom_range(1, 32'h7FFF_FFFF));
    req_valid = 4'b0010;
    div_lat   = 2;
    serve(1'b0, 10, 4'b1101, "bp");
    serve(1'b0, 1, 4'b0, "bp_next");
    req_valid = 4'b0;

    // Reset in the middle of a hung job granted to requester 2.
    set_ops(2, 32'h0003_0000, 32'h0001_0000);
    req_valid = 4'b0100;
    div_hang  = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (req_ready != 4'b0) break;
      @(negedge clk);
    end
    check("midrst grant", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = 4'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("midrst resp_valid", 64'(resp_valid), 64'd0);
      check("midrst resp_data", 64'(resp_data), 64'd0);
      check("midrst div_in_valid", 64'(div_in_valid), 64'd0);
      check("midrst div_n", 64'(div_n), 64'd0);
      check("midrst div_rst", 64'(div_rst), 64'd1);
    end
    rst       = 1'b1;
    model_ptr = 0;
    div_hang  = 1'b0;
    div_lat   = 4;
    set_ops(2, 32'h0009_0000, 32'h0003_0000);
    set_ops(3, 32'hFFF8_0000, 32'h0002_0000);
    req_valid = 4'b1100;
    #1;
    check("postrst resp_valid", 64'(resp_valid), 64'd0);
    serve(1'b0, 1, 4'b0, "postrst_first");
    serve(1'b0, 1, 4'b0, "postrst_second");
    req_valid = 4'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
